// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into word accesses on a word-only memory,
// using read-modify-write for sub-word stores. Define MISALIGN_TRAP_EN to trap misaligned half/word.
module load_store_unit #(
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_BYTES  = 16384
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_error,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  output logic                  mem_we
);
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t                  state_q, state_d;
  logic                    req_ready_q, req_ready_d;
  logic                    resp_valid_q, resp_valid_d;
  logic [31:0]             resp_rdata_q, resp_rdata_d;
  logic                    resp_error_q, resp_error_d;
  logic [ADDR_WIDTH-1:0]   mem_address_q, mem_address_d;
  logic [31:0]             mem_wdata_q, mem_wdata_d;
  logic                    mem_we_q, mem_we_d;
  logic                    we_q, we_d;
  logic [1:0]              size_q, size_d;
  logic                    uns_q, uns_d;
  logic [1:0]              off_q, off_d;
  logic [15:0]             wdata_q, wdata_d;

  logic                    accept;
  logic                    is_half;
  logic                    is_word;
  logic                    range_err;
  logic                    req_err;
  logic [1:0]              lane_off;

  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   load_extend = {{24{b[7] & ~uns}}, b};
      2'b01:   load_extend = {{16{h[15] & ~uns}}, h};
      default: load_extend = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [15:0] wdata,
                                               input logic [1:0] size, input logic [1:0] off);
    logic [31:0] r;
    r = word;
    case (size)
      2'b00: r[{off, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (off[1]) r[31:16] = wdata;
        else        r[15:0]  = wdata;
      end
      default: r = word;
    endcase
    return r;
  endfunction

  always_comb begin
    accept    = req_valid & req_ready_q;
    is_half   = (req_size == 2'b01);
    is_word   = req_size[1];
    range_err = (req_addr >= MEM_LIMIT);
`ifdef MISALIGN_TRAP_EN
    req_err   = range_err | (is_half & req_addr[0]) | (is_word & (req_addr[1:0] != 2'b00));
`else
    req_err   = range_err;
`endif
    // Natural alignment of the lane offset; a trapped access never uses it.
    lane_off  = is_word ? 2'b00 : (is_half ? {req_addr[1], 1'b0} : req_addr[1:0]);

    state_d       = state_q;
    resp_valid_d  = 1'b0;
    resp_rdata_d  = resp_rdata_q;
    resp_error_d  = resp_error_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_we_d      = 1'b0;
    we_d          = we_q;
    size_d        = size_q;
    uns_d         = uns_q;
    off_d         = off_q;
    wdata_d       = wdata_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d          = req_we;
          size_d        = req_size;
          uns_d         = req_unsigned;
          off_d         = lane_off;
          wdata_d       = req_wdata[15:0];
          mem_address_d = {req_addr[ADDR_WIDTH-1:2], 2'b00};
          if (req_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = 32'd0;
            resp_error_d = 1'b1;
          end else if (req_we && is_word) begin
            state_d     = WRITE;
            mem_wdata_d = req_wdata;
            mem_we_d    = 1'b1;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          state_d     = WRITE;
          mem_wdata_d = store_merge(mem_rdata, wdata_q, size_q, off_q);
          mem_we_d    = 1'b1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_rdata_d = load_extend(mem_rdata, size_q, off_q, uns_q);
          resp_error_d = 1'b0;
        end
      end
      WRITE: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = 32'd0;
        resp_error_d = 1'b0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      req_ready_q   <= 1'b1;
      resp_valid_q  <= 1'b0;
      resp_rdata_q  <= 32'd0;
      resp_error_q  <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= 32'd0;
      mem_we_q      <= 1'b0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      uns_q         <= 1'b0;
      off_q         <= 2'b00;
      wdata_q       <= 16'd0;
    end else begin
      state_q       <= state_d;
      req_ready_q   <= req_ready_d;
      resp_valid_q  <= resp_valid_d;
      resp_rdata_q  <= resp_rdata_d;
      resp_error_q  <= resp_error_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_we_q      <= mem_we_d;
      we_q          <= we_d;
      size_q        <= size_d;
      uns_q         <= uns_d;
      off_q         <= off_d;
      wdata_q       <= wdata_d;
    end
  end

  assign req_ready   = req_ready_q;
  assign resp_valid  = resp_valid_q;
  assign resp_rdata  = resp_rdata_q;
  assign resp_error  = resp_error_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_we      = mem_we_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-array reference model, word memory around the DUT,
// one compare process checking outputs every cycle.
module tb_load_store_unit;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_we;

  logic [31:0] mem_env [0:4095];
  logic [7:0]  ref_mem [0:16383];
  logic        pl_we = 1'b0;
  logic [11:0] pl_idx = 12'd0;
  logic [31:0] pl_val = 32'd0;

  int cyc = 0;
  int tests = 0;
  int fails = 0;
  int issue_id = 0;
  int done_id = 0;
  logic skip = 1'b0;

  int          acc;
  int          exp_cyc;
  logic [31:0] exp_rdata;
  logic        exp_err;
  int          exp_we;
  logic [31:0] exp_waddr;
  logic [11:0] exp_idx;
  logic        exp_chk_mem;
  logic        lit_en;
  logic [31:0] lit_rdata;
  logic        lit_err;
  int          lit_lat;
  logic        lit_mem_en;
  logic [31:0] lit_mem_val;

  load_store_unit dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_we(mem_we)
  );

  always #5 clock = ~clock;

  assign mem_rdata = mem_env[mem_address[13:2]];

  initial forever begin
    @(posedge clock);
    cyc <= cyc + 1;
    if (pl_we) mem_env[pl_idx] <= pl_val;
    else if (mem_we) mem_env[mem_address[13:2]] <= mem_wdata;
  end

  function automatic logic [31:0] ref_word(input logic [11:0] idx);
    return {ref_mem[{idx, 2'd3}], ref_mem[{idx, 2'd2}], ref_mem[{idx, 2'd1}], ref_mem[{idx, 2'd0}]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Compare process: every negedge, outputs against the model's expectations.
  initial begin : compare
    logic pend;
    int   we_cnt;
    logic prev_resp;
    we_cnt = 0;
    prev_resp = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_error", 32'(resp_error), 32'd0);
        chk("rst_mem_address", mem_address, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        we_cnt = 0;
        prev_resp = 1'b0;
      end else if (!skip) begin
        pend = (issue_id != done_id);
        if (prev_resp) chk("ready_after_resp", 32'(req_ready), 32'd1);
        prev_resp = 1'b0;
        if (mem_we) begin
          if (pend) begin
            we_cnt++;
            chk("we_address", mem_address, exp_waddr);
          end else begin
            chk("we_while_idle", 32'(mem_we), 32'd0);
          end
        end
        if (!pend) begin
          chk("valid_idle", 32'(resp_valid), 32'd0);
        end else begin
          chk("ready_busy", 32'(req_ready), 32'd0);
          if (cyc == exp_cyc) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_rdata", resp_rdata, exp_rdata);
            chk("resp_error", 32'(resp_error), 32'(exp_err));
            chk("we_cycles", 32'(we_cnt), 32'(exp_we));
            if (exp_chk_mem) chk("mem_word", mem_env[exp_idx], ref_word(exp_idx));
            if (lit_en) begin
              chk("lit_rdata", resp_rdata, lit_rdata);
              chk("lit_error", 32'(resp_error), 32'(lit_err));
              chk("lit_latency", 32'(cyc - acc + 1), 32'(lit_lat));
              if (lit_mem_en) chk("lit_mem_word", mem_env[exp_idx], lit_mem_val);
            end
            we_cnt = 0;
            done_id++;
            prev_resp = 1'b1;
          end else begin
            chk("valid_early", 32'(resp_valid), 32'd0);
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int guard;
    guard = 0;
    @(negedge clock);
    while (!req_ready) begin
      guard++;
      if (guard > 50) begin
        $display("FAIL ready_timeout: req_ready stuck at 0");
        $fatal(1);
      end
      @(negedge clock);
    end
  endtask

  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic le, input logic [31:0] lr, input logic lerr, input int llat,
                        input logic lme, input logic [31:0] lmv);
    int          n;
    int          lat;
    int          guard;
    logic        mis;
    logic        err;
    logic [31:0] ea;
    logic [31:0] v;
    wait_ready();
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clock);
    #1;
    acc = cyc;
    req_valid = 1'b0; req_we = ~we; req_size = size + 2'd1; req_unsigned = ~uns;
    req_addr = $urandom; req_wdata = $urandom;

    n = (size == 2'd0) ? 1 : ((size == 2'd1) ? 2 : 4);
`ifdef MISALIGN_TRAP_EN
    mis = (addr % 32'(n)) != 32'd0;
    ea  = addr;
`else
    mis = 1'b0;
    ea  = addr - (addr % 32'(n));
`endif
    err = mis || (addr >= 32'd16384);
    lat = err ? 1 : (!we ? 2 : ((n == 4) ? 2 : 3));
    v = 32'd0;
    if (!err) begin
      for (int i = 0; i < n; i++) v = v | ({24'd0, ref_mem[ea + 32'(i)]} << (8 * i));
      if (!uns && n < 4 && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      if (we) for (int i = 0; i < n; i++) ref_mem[ea + 32'(i)] = wdata[8 * i +: 8];
    end
    exp_rdata   = (err || we) ? 32'd0 : v;
    exp_err     = err;
    exp_we      = (!err && we) ? 1 : 0;
    exp_waddr   = {addr[31:2], 2'b00};
    exp_idx     = addr[13:2];
    exp_chk_mem = !err;
    exp_cyc     = acc - 1 + lat;
    lit_en = le; lit_rdata = lr; lit_err = lerr; lit_lat = llat; lit_mem_en = lme; lit_mem_val = lmv;
    issue_id++;

    guard = 0;
    while (done_id != issue_id) begin
      @(negedge clock);
      guard++;
      if (guard > 20) begin
        $display("FAIL resp_timeout: no response for request at %h", addr);
        $fatal(1);
      end
    end
  endtask

  initial begin : main
    logic [31:0] w;
    for (int i = 0; i < 4096; i++) begin
      @(negedge clock);
      w = $urandom;
      if (i == 'h40) w = 32'h8040_20F0;
      if (i == 'h80) w = 32'h1122_3344;
      pl_we = 1'b1; pl_idx = 12'(i); pl_val = w;
      for (int b = 0; b < 4; b++) ref_mem[4 * i + b] = w[8 * b +: 8];
    end
    @(negedge clock);
    pl_we = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;

    do_req(1'b0, 2'd0, 1'b0, 32'h100, $urandom, 1'b1, 32'hFFFF_FFF0, 1'b0, 2, 1'b0, 32'd0);
    do_req(1'b0, 2'd0, 1'b1, 32'h100, $urandom, 1'b1, 32'h0000_00F0, 1'b0, 2, 1'b0, 32'd0);
    do_req(1'b0, 2'd1, 1'b0, 32'h102, $urandom, 1'b1, 32'hFFFF_8040, 1'b0, 2, 1'b0, 32'd0);
    do_req(1'b0, 2'd1, 1'b1, 32'h102, $urandom, 1'b1, 32'h0000_8040, 1'b0, 2, 1'b0, 32'd0);
    do_req(1'b1, 2'd0, 1'b0, 32'h201, 32'h5555_55AA, 1'b1, 32'd0, 1'b0, 3, 1'b1, 32'h1122_AA44);
    do_req(1'b1, 2'd2, 1'b0, 32'h300, 32'hDEAD_BEEF, 1'b1, 32'd0, 1'b0, 2, 1'b1, 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h300, $urandom, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'd0);
`ifdef MISALIGN_TRAP_EN
    do_req(1'b0, 2'd2, 1'b0, 32'h302, $urandom, 1'b1, 32'd0, 1'b1, 1, 1'b0, 32'd0);
`else
    do_req(1'b0, 2'd2, 1'b0, 32'h302, $urandom, 1'b1, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 32'd0);
`endif
    do_req(1'b0, 2'd2, 1'b0, 32'h4000, $urandom, 1'b1, 32'd0, 1'b1, 1, 1'b0, 32'd0);
    do_req(1'b1, 2'd2, 1'b0, 32'h4000, 32'h1234_5678, 1'b1, 32'd0, 1'b1, 1, 1'b0, 32'd0);

    // Reset in the WRITE cycle of a byte store: the store must not land.
    skip = 1'b1;
    wait_ready();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h202; req_wdata = 32'h0000_0077;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(posedge clock);
    #2 reset_n = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    skip = 1'b0;
    do_req(1'b0, 2'd2, 1'b0, 32'h200, $urandom, 1'b1, 32'h1122_AA44, 1'b0, 2, 1'b0, 32'd0);

    for (int t = 0; t < 400; t++) begin
      int          r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r == 0)      a = $urandom;
      else if (r == 1) a = 32'h3FF0 + $urandom_range(0, 31);
      else             a = $urandom_range(0, 'h7FF);
      repeat ($urandom_range(0, 2)) @(negedge clock);
      do_req(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             a, $urandom, 1'b0, 32'd0, 1'b0, 0, 1'b0, 32'd0);
    end

    repeat (3) @(negedge clock);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
